// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: oversamples BCLK/LRCK/SDATA in the system clock
// domain and delivers each completed left/right sample pair with a valid pulse.
module i2s_rx_deser #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              sdata,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              frame_valid,
  output logic              slot_err,
  output logic              locked
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic                   bclk_dly_q;

  logic              prev_ws_q, prev_ws_d;
  chan_e             chan_q, chan_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              left_ok_q, left_ok_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              frame_valid_q, frame_valid_d;
  logic              slot_err_q, slot_err_d;

  logic bclk_s, ws, d, rise;

  // All three inputs share the same depth so LRCK/SDATA stay aligned with BCLK.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      bclk_dly_q   <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
      bclk_dly_q   <= bclk_s;
    end
  end

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign ws     = lrck_sync_q[SYNC_STAGES-1];
  assign d      = sdata_sync_q[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_dly_q;

  // A WS change marks the I2S delay bit: close the old slot, open the new one.
  always_comb begin
    prev_ws_d     = prev_ws_q;
    chan_d        = chan_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    left_ok_d     = left_ok_q;
    locked_d      = locked_q;
    left_d        = left_q;
    right_d       = right_q;
    frame_valid_d = 1'b0;
    slot_err_d    = 1'b0;

    if (rise) begin
      if (ws != prev_ws_q) begin
        if (locked_q) begin
          if (bit_cnt_q == CNT_FULL) begin
            if (chan_q == CH_LEFT) begin
              left_d    = shift_q;
              left_ok_d = 1'b1;
            end else begin
              right_d = shift_q;
              if (left_ok_q) begin
                frame_valid_d = 1'b1;
                left_ok_d     = 1'b0;
              end
            end
          end else begin
            slot_err_d = 1'b1;
            left_ok_d  = 1'b0;
          end
        end
        bit_cnt_d = '0;
        chan_d    = chan_e'(ws);
        prev_ws_d = ws;
        locked_d  = 1'b1;
      end else if (locked_q && (bit_cnt_q < CNT_FULL)) begin
        shift_d   = {shift_q[DATA_W-2:0], d};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Capture is enabled exactly from the first transition, so locked doubles as the capturing flag.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prev_ws_q     <= 1'b0;
      chan_q        <= CH_LEFT;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      left_ok_q     <= 1'b0;
      locked_q      <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      frame_valid_q <= 1'b0;
      slot_err_q    <= 1'b0;
    end else begin
      prev_ws_q     <= prev_ws_d;
      chan_q        <= chan_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      left_ok_q     <= left_ok_d;
      locked_q      <= locked_d;
      left_q        <= left_d;
      right_q       <= right_d;
      frame_valid_q <= frame_valid_d;
      slot_err_q    <= slot_err_d;
    end
  end

  assign left_data   = left_q;
  assign right_data  = right_q;
  assign frame_valid = frame_valid_q;
  assign slot_err    = slot_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: BCLK = clk_in/4, slots built bit by bit.
module tb_i2s_rx_deser;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        bclk;
  logic        lrck;
  logic        sdata;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        frame_valid;
  logic        slot_err;
  logic        locked;

  int testsRun  = 0;
  int failCount = 0;

  int          fvCount = 0;
  int          errCount = 0;
  int          bothCount = 0;
  int          fvRun = 0, fvMaxRun = 0;
  int          errRun = 0, errMaxRun = 0;
  logic [15:0] fvLeft = '0;
  logic [15:0] fvRight = '0;
  int          fvBase, errBase;

  i2s_rx_deser #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .bclk        (bclk),
    .lrck        (lrck),
    .sdata       (sdata),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_valid (frame_valid),
    .slot_err    (slot_err),
    .locked      (locked)
  );

  always #10 clk_in = ~clk_in;

  // Pulse recorder: counts, widths and the data seen alongside each frame_valid.
  always @(negedge clk_in) begin
    if (frame_valid) begin
      fvCount++;
      fvLeft  = left_data;
      fvRight = right_data;
      fvRun++;
    end else begin
      fvRun = 0;
    end
    if (slot_err) begin
      errCount++;
      errRun++;
    end else begin
      errRun = 0;
    end
    if (frame_valid && slot_err) bothCount++;
    if (fvRun > fvMaxRun) fvMaxRun = fvRun;
    if (errRun > errMaxRun) errMaxRun = errRun;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_left"}, 32'(left_data), 32'h0);
    checkOutput({tag, "_right"}, 32'(right_data), 32'h0);
    checkOutput({tag, "_fv"}, 32'(frame_valid), 32'h0);
    checkOutput({tag, "_err"}, 32'(slot_err), 32'h0);
    checkOutput({tag, "_locked"}, 32'(locked), 32'h0);
  endtask

  // One BCLK period: data/WS change on the falling edge, sampled on the rising edge.
  task automatic bclkCycle(input logic ws, input logic bitVal);
    bclk  = 1'b0;
    lrck  = ws;
    sdata = bitVal;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // Rise 0 is the delay bit (sent as 1), then the word MSB first, then 1s as padding.
  task automatic applyStimulus(input logic ws, input logic [31:0] word,
                               input int wordBits, input int slotLen);
    logic bitVal;
    for (int k = 0; k < slotLen; k++) begin
      if (k == 0) bitVal = 1'b1;
      else if (k <= wordBits) bitVal = word[wordBits-k];
      else bitVal = 1'b1;
      bclkCycle(ws, bitVal);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bclk  = 1'b0;
    lrck  = 1'b0;
    sdata = 1'b0;
    #43;
    checkResetState("por");
    rst_n = 1'b1;
    #40;

    // Nominal 32-bit slots, A5C3 / 0F81.
    applyStimulus(1'b0, 32'hA5C3, 16, 32);
    checkOutput("t1_prelock", 32'(locked), 32'h0);
    applyStimulus(1'b1, 32'h0F81, 16, 32);
    checkOutput("t1_locked", 32'(locked), 32'h1);
    applyStimulus(1'b0, 32'hA5C3, 16, 32);
    checkOutput("t1_right", 32'(right_data), 32'h0F81);
    checkOutput("t1_fv_none_a", 32'(fvCount), 32'd0);
    applyStimulus(1'b1, 32'h0F81, 16, 32);
    checkOutput("t1_left", 32'(left_data), 32'hA5C3);
    checkOutput("t1_fv_none_b", 32'(fvCount), 32'd0);
    applyStimulus(1'b0, 32'hA5C3, 16, 32);
    checkOutput("t1_fv_one", 32'(fvCount), 32'd1);
    checkOutput("t1_fv_left", 32'(fvLeft), 32'hA5C3);
    checkOutput("t1_fv_right", 32'(fvRight), 32'h0F81);
    applyStimulus(1'b1, 32'h0F81, 16, 32);
    applyStimulus(1'b0, 32'hA5C3, 16, 32);
    checkOutput("t1_fv_two", 32'(fvCount), 32'd2);
    checkOutput("t1_no_err", 32'(errCount), 32'd0);

    // Reset while LRCK is high so the stream starts in a right slot.
    bclk = 1'b0;
    #40;
    rst_n = 1'b0;
    lrck  = 1'b1;
    #60;
    checkOutput("t2_reset_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;
    #40;
    fvBase = fvCount;
    applyStimulus(1'b1, 32'h1234, 16, 32);
    checkOutput("t2_locked", 32'(locked), 32'h1);
    applyStimulus(1'b0, 32'h1111, 16, 32);
    checkOutput("t2_right_only", 32'(right_data), 32'h1234);
    checkOutput("t2_fv_none", 32'(fvCount), 32'(fvBase));
    applyStimulus(1'b1, 32'h2222, 16, 32);
    applyStimulus(1'b0, 32'h7E57, 16, 32);
    checkOutput("t2_fv_one", 32'(fvCount), 32'(fvBase + 1));
    checkOutput("t2_fv_left", 32'(fvLeft), 32'h1111);
    checkOutput("t2_fv_right", 32'(fvRight), 32'h2222);

    // Short left slot of 10 rises.
    applyStimulus(1'b1, 32'h3333, 16, 32);
    applyStimulus(1'b0, 32'h0F0F, 16, 10);
    checkOutput("t3_prev_fv", 32'(fvCount), 32'(fvBase + 2));
    checkOutput("t3_prev_fv_left", 32'(fvLeft), 32'h7E57);
    checkOutput("t3_prev_fv_right", 32'(fvRight), 32'h3333);
    fvBase  = fvCount;
    errBase = errCount;
    applyStimulus(1'b1, 32'hCAFE, 16, 32);
    checkOutput("t3_err", 32'(errCount), 32'(errBase + 1));
    checkOutput("t3_left_kept", 32'(left_data), 32'h7E57);
    applyStimulus(1'b0, 32'hBEEF, 16, 32);
    checkOutput("t3_fv_none", 32'(fvCount), 32'(fvBase));
    checkOutput("t3_right", 32'(right_data), 32'hCAFE);
    applyStimulus(1'b1, 32'hCAFE, 16, 32);
    applyStimulus(1'b0, 32'h8001, 16, 17);
    checkOutput("t3_fv_one", 32'(fvCount), 32'(fvBase + 1));
    checkOutput("t3_fv_left", 32'(fvLeft), 32'hBEEF);
    checkOutput("t3_fv_right", 32'(fvRight), 32'hCAFE);

    // Exact-minimum 17-rise slots.
    applyStimulus(1'b1, 32'h8001, 16, 17);
    applyStimulus(1'b0, 32'hFEDCBA, 24, 25);
    checkOutput("t4_fv", 32'(fvCount), 32'(fvBase + 2));
    checkOutput("t4_fv_left", 32'(fvLeft), 32'h8001);
    checkOutput("t4_fv_right", 32'(fvRight), 32'h8001);
    checkOutput("t4_no_err", 32'(errCount), 32'(errBase + 1));

    // Long 24-bit words: trailing bits dropped.
    applyStimulus(1'b1, 32'h123456, 24, 25);
    checkOutput("t6_left_trunc", 32'(left_data), 32'hFEDC);
    checkOutput("t6_no_err", 32'(errCount), 32'(errBase + 1));
    applyStimulus(1'b0, 32'h5555, 16, 9);
    checkOutput("t6_fv", 32'(fvCount), 32'(fvBase + 3));
    checkOutput("t6_fv_right", 32'(fvRight), 32'h1234);

    // Reset after 8 bits of a left slot.
    bclk  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkResetState("mid");
    rst_n = 1'b1;
    #40;
    fvBase = fvCount;
    applyStimulus(1'b0, 32'h5555, 16, 32);
    checkOutput("t5_prelock", 32'(locked), 32'h0);
    applyStimulus(1'b1, 32'hAAAA, 16, 32);
    checkOutput("t5_locked", 32'(locked), 32'h1);
    applyStimulus(1'b0, 32'h5555, 16, 32);
    checkOutput("t5_fv_none_a", 32'(fvCount), 32'(fvBase));
    checkOutput("t5_right", 32'(right_data), 32'hAAAA);
    applyStimulus(1'b1, 32'hAAAA, 16, 32);
    checkOutput("t5_fv_none_b", 32'(fvCount), 32'(fvBase));
    applyStimulus(1'b0, 32'h5555, 16, 32);
    checkOutput("t5_fv_one", 32'(fvCount), 32'(fvBase + 1));
    checkOutput("t5_fv_left", 32'(fvLeft), 32'h5555);
    checkOutput("t5_fv_right", 32'(fvRight), 32'hAAAA);

    checkOutput("fv_width", 32'(fvMaxRun), 32'd1);
    checkOutput("err_width", 32'(errMaxRun), 32'd1);
    checkOutput("err_total", 32'(errCount), 32'd1);
    checkOutput("fv_err_overlap", 32'(bothCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
